muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add / restoring shift-subtract
// datapath sequenced over XLEN cycles, with direct-to-DONE special cases.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; operands captured on acceptance
// CALC  | one multiply or divide iteration per cycle, counter 0..XLEN-1
// DONE  | o_done pulse, o_result holds the finished value
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct_3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     count_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_q;
    logic              neg_rem_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN:0]     rem_q;

    logic            rs1_signed, rs2_signed, s1, s2;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            accept, last_iter, is_div;

    // Operand decode and special-case detection on the raw request
    always_comb begin
        rs1_signed  = (i_funct_3 == 3'b001) || (i_funct_3 == 3'b010) ||
                      (i_funct_3 == 3'b100) || (i_funct_3 == 3'b110);
        rs2_signed  = (i_funct_3 == 3'b001) || (i_funct_3 == 3'b100) ||
                      (i_funct_3 == 3'b110);
        s1          = rs1_signed & i_rs1[XLEN-1];
        s2          = rs2_signed & i_rs2[XLEN-1];
        rs1_mag     = s1 ? -i_rs1 : i_rs1;
        rs2_mag     = s2 ? -i_rs2 : i_rs2;
        div_zero    = i_funct_3[2] && (i_rs2 == '0);
        div_ovf     = i_funct_3[2] && !i_funct_3[0] &&
                      (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = i_funct_3[1] ? i_rs1 : '1;
        else
            special_res = i_funct_3[1] ? '0 : i_rs1;
    end

    assign accept    = (state_q == IDLE) && i_start && !i_flush;
    assign last_iter = (state_q == CALC) && (count_q == CW'(XLEN-1));
    assign is_div    = funct3_q[2];

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

    // One iteration: the low half of acc_q holds the multiplier or the dividend/quotient
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_diff = {rem_q, acc_q[XLEN-1]} - {2'b00, opnd_q};
        div_ge   = !div_diff[XLEN+1];
        rem_next = div_ge ? div_diff[XLEN:0] : {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        quo_next = {acc_q[XLEN-2:0], div_ge};
        acc_next = is_div ? {acc_q[2*XLEN-1:XLEN], quo_next} : mul_next;

        prod_fix = neg_q ? -mul_next : mul_next;
        quo_fix  = neg_q ? -quo_next : quo_next;
        rem_fix  = neg_rem_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];

        calc_res = '0;
        case (funct3_q)
            3'b000:                 calc_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = quo_fix;
            default:                calc_res = rem_fix;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = special ? DONE : CALC;
            end
            CALC: begin
                if (last_iter)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush)
            state_d = IDLE;
    end

    always_comb begin
        o_busy = (state_q != IDLE);
        o_done = (state_q == DONE);
    end

    // o_result loads only on the edge that enters DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q   <= '0;
            funct3_q  <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            rem_q     <= '0;
            o_result  <= '0;
        end else if (accept) begin
            count_q   <= '0;
            funct3_q  <= i_funct_3;
            opnd_q    <= i_funct_3[2] ? rs2_mag : rs1_mag;
            acc_q     <= {{XLEN{1'b0}}, (i_funct_3[2] ? rs1_mag : rs2_mag)};
            rem_q     <= '0;
            neg_q     <= s1 ^ s2;
            neg_rem_q <= s1;
            if (special)
                o_result <= special_res;
        end else if ((state_q == CALC) && !i_flush) begin
            count_q <= count_q + 1'b1;
            acc_q   <= acc_next;
            if (is_div)
                rem_q <= rem_next;
            if (last_iter)
                o_result <= calc_res;
        end
    end

endmodule
